// File: rtl/vga_plot_pkg.sv
// Shared definitions for the Avalon-MM pixel plotter: register map,
// PLOT/CLEAR field positions, FSM encoding and the queued pixel record.
package vga_plot_pkg;

  localparam logic [1:0] ADDR_PLOT    = 2'd0;
  localparam logic [1:0] ADDR_CLEAR   = 2'd1;
  localparam logic [1:0] ADDR_STATUS  = 2'd2;
  localparam logic [1:0] ADDR_DROPPED = 2'd3;

  localparam int PLOT_Y_MSB = 30;
  localparam int PLOT_Y_LSB = 24;
  localparam int PLOT_X_MSB = 23;
  localparam int PLOT_X_LSB = 16;
  localparam int COL_MSB    = 7;
  localparam int COL_LSB    = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  typedef struct packed {
    logic [6:0] y;
    logic [7:0] x;
    logic [7:0] colour;
  } pixel_t;

endpackage

// File: rtl/plot_fifo.sv
// First-word fall-through pixel queue. Head entry is visible on o_data while
// non-empty; a pop at full frees the slot for a same-cycle push.
module plot_fifo
  import vga_plot_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  pixel_t                   i_data,
  input  logic                     i_pop,
  output pixel_t                   o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);

  pixel_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wp, r_rp;
  logic [AW:0]     r_lvl;
  logic            w_do_push, w_do_pop;

  assign o_full    = (r_lvl == (AW+1)'(DEPTH));
  assign o_empty   = (r_lvl == '0);
  assign o_level   = r_lvl;
  assign o_data    = r_mem[r_rp];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage write; contents need no reset since level gates visibility.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wp] <= i_data;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_lvl <= '0;
    end else begin
      if (w_do_push) r_wp <= r_wp + 1'b1;
      if (w_do_pop)  r_rp <= r_rp + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_lvl <= r_lvl + 1'b1;
        2'b01:   r_lvl <= r_lvl - 1'b1;
        default: r_lvl <= r_lvl;
      endcase
    end
  end

endmodule

// File: rtl/vga_plot_avalon.sv
// Avalon-MM slave that queues single-pixel plots and performs full-screen
// clears, driving a one-pixel-per-cycle VGA adapter plot interface.
module vga_plot_avalon
  import vga_plot_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int H_RES      = 160,
  parameter int V_RES      = 120
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic        read,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [7:0]  vga_colour,
  output logic        vga_plot
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  state_t        r_state, w_state_nxt;
  pixel_t        w_wr_px, w_fifo_q;
  logic          w_fifo_full, w_fifo_empty;
  logic [LW-1:0] w_fifo_level;
  logic          w_is_plot, w_is_clear, w_px_ok;
  logic          w_pop, w_push, w_push_stall, w_clr_ok, w_clr_acc;
  logic          w_sweep_last, w_busy;
  logic          w_unused_wd;

  logic [7:0]    r_sx, r_vx, r_vc, r_fill;
  logic [6:0]    r_sy, r_vy;
  logic          r_plot;
  logic [31:0]   r_dropped, r_rdata;

  assign w_wr_px.y      = writedata[PLOT_Y_MSB:PLOT_Y_LSB];
  assign w_wr_px.x      = writedata[PLOT_X_MSB:PLOT_X_LSB];
  assign w_wr_px.colour = writedata[COL_MSB:COL_LSB];
  assign w_unused_wd    = ^{writedata[31], writedata[15:8]};

  assign w_is_plot  = write && (address == ADDR_PLOT);
  assign w_is_clear = write && (address == ADDR_CLEAR);
  assign w_px_ok    = ({1'b0, w_wr_px.x} < 9'(H_RES)) && ({1'b0, w_wr_px.y} < 8'(V_RES));

  // Queue drains whenever no sweep owns the plot port, so the first pop
  // already happens in the IDLE->DRAIN cycle.
  assign w_pop        = (r_state != ST_CLEAR) && !w_fifo_empty;
  assign w_push_stall = w_is_plot && w_px_ok && w_fifo_full && !w_pop;
  assign w_push       = w_is_plot && w_px_ok && !w_push_stall;
  // CLEAR only starts once everything queued ahead of it has been plotted.
  assign w_clr_ok     = (r_state == ST_IDLE) && w_fifo_empty;
  assign w_clr_acc    = w_is_clear && w_clr_ok;
  assign waitrequest  = w_push_stall || (w_is_clear && !w_clr_ok);

  assign w_sweep_last = (r_sx == 8'(H_RES-1)) && (r_sy == 7'(V_RES-1));
  assign w_busy       = (r_state != ST_IDLE) || !w_fifo_empty;

  assign vga_x      = r_vx;
  assign vga_y      = r_vy;
  assign vga_colour = r_vc;
  assign vga_plot   = r_plot;
  assign readdata   = r_rdata;

  plot_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_wr_px),
    .i_pop   (w_pop),
    .o_data  (w_fifo_q),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_level (w_fifo_level)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state: leave DRAIN together with the pop of the last entry.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_clr_acc)          w_state_nxt = ST_CLEAR;
        else if (!w_fifo_empty) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_fifo_empty || (w_fifo_level == LW'(1) && !w_push))
          w_state_nxt = ST_IDLE;
      end
      ST_CLEAR: begin
        if (w_sweep_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Plot port and sweep counters; pixel outputs hold between strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_plot <= 1'b0;
      r_vx   <= '0;
      r_vy   <= '0;
      r_vc   <= '0;
      r_sx   <= '0;
      r_sy   <= '0;
      r_fill <= '0;
    end else begin
      r_plot <= 1'b0;
      if (r_state == ST_CLEAR) begin
        r_vx   <= r_sx;
        r_vy   <= r_sy;
        r_vc   <= r_fill;
        r_plot <= 1'b1;
        if (r_sx == 8'(H_RES-1)) begin
          r_sx <= '0;
          r_sy <= (r_sy == 7'(V_RES-1)) ? 7'd0 : r_sy + 1'b1;
        end else begin
          r_sx <= r_sx + 1'b1;
        end
      end else if (w_pop) begin
        r_vx   <= w_fifo_q.x;
        r_vy   <= w_fifo_q.y;
        r_vc   <= w_fifo_q.colour;
        r_plot <= 1'b1;
      end
      if (w_clr_acc) begin
        r_fill <= writedata[COL_MSB:COL_LSB];
        r_sx   <= '0;
        r_sy   <= '0;
      end
    end
  end

  // Saturating count of off-screen plots.
  always_ff @(posedge clk) begin
    if (reset)                                       r_dropped <= '0;
    else if (w_is_plot && !w_px_ok && ~&r_dropped)   r_dropped <= r_dropped + 1'b1;
  end

  // Read port, one-cycle latency, side-effect free.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (read) begin
      case (address)
        ADDR_STATUS:  r_rdata <= {w_busy, 23'b0, 8'(w_fifo_level)};
        ADDR_DROPPED: r_rdata <= r_dropped;
        default:      r_rdata <= '0;
      endcase
    end else begin
      r_rdata <= '0;
    end
  end

endmodule

// File: tb/tb_vga_plot_avalon.sv
// Randomized bench: every accepted write is turned into the pixel sequence it
// must produce, and a monitor matches each plot strobe against that sequence.
module tb_vga_plot_avalon;
  import vga_plot_pkg::*;

  localparam int H = 160;
  localparam int V = 120;
  localparam int D = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        write, read;
  logic [31:0] writedata, readdata;
  logic        waitrequest;
  logic [7:0]  vga_x, vga_colour;
  logic [6:0]  vga_y;
  logic        vga_plot;

  int          n_chk = 0;
  int          n_err = 0;
  int          q_exp[$];
  int unsigned m_drop = 0;
  int          obs_cnt = 0;

  vga_plot_avalon #(.FIFO_DEPTH(D), .H_RES(H), .V_RES(V)) dut (
    .clk(clk), .reset(reset), .address(address), .write(write),
    .writedata(writedata), .read(read), .readdata(readdata),
    .waitrequest(waitrequest), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int pk(input int x, input int y, input int c);
    return (y << 16) | (x << 8) | c;
  endfunction

  // Reference: what an accepted write contributes to the plot stream.
  task automatic model_acc(input logic [1:0] a, input logic [31:0] d);
    int x, y, c;
    x = int'(d[23:16]);
    y = int'(d[30:24]);
    c = int'(d[7:0]);
    if (a == ADDR_PLOT) begin
      if (x < H && y < V) q_exp.push_back(pk(x, y, c));
      else if (m_drop != 32'hFFFF_FFFF) m_drop++;
    end else if (a == ADDR_CLEAR) begin
      for (int yy = 0; yy < V; yy++)
        for (int xx = 0; xx < H; xx++)
          q_exp.push_back(pk(xx, yy, c));
    end
  endtask

  always @(negedge clk) begin
    if (!reset && vga_plot) begin
      obs_cnt++;
      if (q_exp.size() == 0) chk("extra_plot", {9'b0, vga_y, vga_x, vga_colour}, 32'hFFFF_FFFF);
      else                   chk("pixel", {9'b0, vga_y, vga_x, vga_colour}, q_exp.pop_front());
    end
  end

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d, output int waits);
    waits = 0;
    @(negedge clk);
    write = 1'b1; read = 1'b0; address = a; writedata = d;
    forever begin
      #1;
      if (!waitrequest) begin
        @(posedge clk);
        model_acc(a, d);
        break;
      end
      waits++;
      if (waits > 25000) begin
        chk("wr_timeout", waits, 0);
        @(negedge clk);
        write = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    write = 1'b0; read = 1'b1; address = a;
    #1 chk("rd_wait", waitrequest, 0);
    @(posedge clk);
    @(negedge clk);
    read = 1'b0;
    d = readdata;
  endtask

  task automatic bus_idle();
    @(negedge clk);
    write = 1'b0; read = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (q_exp.size() != 0 && k < 30000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 30000) chk("drain_timeout", q_exp.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int w, wsum, base, k, run, x, y, c, r;
    logic [31:0] rd, d;

    reset = 1'b1; write = 1'b0; read = 1'b0; address = '0; writedata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_plot", vga_plot, 0);
    chk("rst_x", vga_x, 0);
    chk("rst_y", vga_y, 0);
    chk("rst_col", vga_colour, 0);
    chk("rst_rdata", readdata, 0);
    chk("rst_wait", waitrequest, 0);
    reset = 1'b0;

    // Single plot latency and pulse width.
    bus_wr(ADDR_PLOT, {1'b0, 7'd7, 8'd5, 8'h00, 8'hAA}, w);
    chk("plot_nowait", w, 0);
    bus_idle();
    chk("lat_early", vga_plot, 0);
    @(negedge clk);
    chk("lat_plot", vga_plot, 1);
    chk("lat_pix", {9'b0, vga_y, vga_x, vga_colour}, pk(5, 7, 8'hAA));
    @(negedge clk);
    chk("pulse_one", vga_plot, 0);
    chk("hold_pix", {9'b0, vga_y, vga_x, vga_colour}, pk(5, 7, 8'hAA));
    bus_rd(ADDR_DROPPED, rd);
    chk("drop0", rd, 0);

    // Off-screen plots.
    bus_wr(ADDR_PLOT, {1'b0, 7'd0, 8'd160, 8'h00, 8'h11}, w);
    chk("drop_x_nowait", w, 0);
    bus_wr(ADDR_PLOT, {1'b0, 7'd120, 8'd0, 8'h00, 8'h22}, w);
    chk("drop_y_nowait", w, 0);
    bus_idle();
    repeat (4) @(negedge clk);
    bus_rd(ADDR_DROPPED, rd);
    chk("drop2", rd, m_drop);

    // Back-to-back plots into an idle block.
    base = obs_cnt;
    for (int i = 0; i < 12; i++) bus_wr(ADDR_PLOT, {8'd0, 8'(i), 8'h00, 8'(i + 1)}, w);
    bus_idle();
    wait_idle();
    chk("b2b_count", obs_cnt - base, 12);

    // Full clear, checking the strobe stays high for the whole sweep.
    bus_wr(ADDR_CLEAR, 32'hFFFF_FF3C, w);
    bus_idle();
    k = 0;
    while (!vga_plot && k < 5) begin @(negedge clk); k++; end
    run = 0;
    while (vga_plot && run < H * V + 10) begin run++; @(negedge clk); end
    chk("clr_run", run, H * V);
    wait_idle();
    bus_rd(ADDR_STATUS, rd);
    chk("clr_status", rd, 0);

    // Plot then CLEAR: clear must wait; plots issued during the sweep fill
    // the queue, stall, and come out after the sweep.
    bus_wr(ADDR_PLOT, {8'd1, 8'd1, 8'h00, 8'h55}, w);
    bus_wr(ADDR_CLEAR, 32'h0000_0000, w);
    chk("clr_waited", w > 0, 1);
    wsum = 0;
    for (int i = 0; i < 12; i++) begin
      bus_wr(ADDR_PLOT, {8'd5, 8'(i), 8'h00, 8'(8'h80 + i)}, w);
      wsum += w;
    end
    chk("full_stall", wsum > 0, 1);
    bus_idle();
    wait_idle();
    bus_rd(ADDR_STATUS, rd);
    chk("order_status", rd, 0);

    // Reset in the middle of a sweep.
    bus_wr(ADDR_CLEAR, 32'h0000_0011, w);
    bus_idle();
    base = obs_cnt;
    k = 0;
    while (obs_cnt - base < 100 && k < 200) begin @(negedge clk); k++; end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    q_exp.delete();
    m_drop = 0;
    chk("rst_mid_plot", vga_plot, 0);
    @(negedge clk);
    chk("rst_mid_plot2", vga_plot, 0);
    bus_rd(ADDR_STATUS, rd);
    chk("rst_mid_status", rd, 0);
    base = obs_cnt;
    bus_wr(ADDR_PLOT, {8'd4, 8'd3, 8'h00, 8'h77}, w);
    bus_idle();
    wait_idle();
    chk("post_rst_plot", obs_cnt - base, 1);

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 99);
      if (i == 75) begin
        bus_wr(ADDR_CLEAR, {24'($urandom), 8'($urandom)}, w);
      end else if (r < 60) begin
        x = $urandom_range(0, 170);
        y = $urandom_range(0, 127);
        c = $urandom_range(0, 255);
        d = {1'($urandom), 7'(y), 8'(x), 8'($urandom), 8'(c)};
        bus_wr(ADDR_PLOT, d, w);
        if (x >= H || y >= V) chk("rnd_drop_nowait", w, 0);
      end else if (r < 80) begin
        bus_rd(ADDR_DROPPED, rd);
        chk("rnd_dropped", rd, m_drop);
      end else begin
        bus_rd(ADDR_STATUS, rd);
        chk("rnd_st_rsvd", {9'b0, rd[30:8]}, 0);
        chk("rnd_st_lvl", 32'(rd[7:0] <= D), 1);
      end
      if (r % 3 == 0) bus_idle();
    end
    bus_idle();
    wait_idle();
    bus_rd(ADDR_STATUS, rd);
    chk("end_status", rd, 0);
    bus_rd(ADDR_DROPPED, rd);
    chk("end_dropped", rd, m_drop);
    chk("end_queue", q_exp.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/vga_plot_avalon.md
VGA_PLOT_AVALON -- requirements
Module: vga_plot_avalon

Interface
REQ-001 SHALL have parameters: FIFO_DEPTH, default 8, plot-request queue depth (power of 2); H_RES, default 160, columns; V_RES, default 120, rows.
REQ-002 SHALL have ports:
- clk  in  1  system clock, all logic rising-edge
- reset  in  1  synchronous, active-high
- address  in  2  Avalon-MM slave word address
- write  in  1  write strobe
- writedata  in  32  write data
- read  in  1  read strobe
- readdata  out  32  read data, fixed read latency 1
- waitrequest  out  1  stalls the current write
- vga_x  out  8  pixel column to VGA adapter
- vga_y  out  7  pixel row to VGA adapter
- vga_colour  out  8  pixel colour
- vga_plot  out  1  one-cycle plot strobe

Function
REQ-003 SHALL use register map: 0 PLOT (W): y=writedata[30:24], x=[23:16], colour=[7:0]; 1 CLEAR (W): fill colour=[7:0]; 2 STATUS (R): {busy, 23'b0, fifo_level[7:0]}; 3 DROPPED (R): 32-bit count of rejected plots.
REQ-004 SHALL discard a PLOT with x>=H_RES or y>=V_RES: accept with no wait, no enqueue, DROPPED +1 (saturating at 0xFFFFFFFF).
REQ-005 SHALL enqueue a valid PLOT when the FIFO is not full; write completes on the edge where write=1 and waitrequest=0.
REQ-006 SHALL hold waitrequest=1 for a valid PLOT while the FIFO is full; accept on the first edge a slot exists; a FIFO pop in the same cycle frees a slot (simultaneous push/pop at full accepted).
REQ-007 SHALL use FSM states IDLE, DRAIN, CLEAR: IDLE->DRAIN when FIFO non-empty; DRAIN->IDLE when last entry popped and no CLEAR pending; IDLE/DRAIN->CLEAR on accepted CLEAR; CLEAR->IDLE after pixel (H_RES-1, V_RES-1).
REQ-008 SHALL in DRAIN pop one entry per cycle and present it on vga_x/vga_y/vga_colour with vga_plot=1 for exactly one cycle.
REQ-009 SHALL produce latency: PLOT accepted on edge E into an empty, idle block -> vga_plot=1 during the cycle following edge E+1.
REQ-010 SHALL hold waitrequest=1 for a CLEAR write until FIFO empty and state IDLE (preserves ordering); CLEAR arriving during CLEAR waits likewise.
REQ-011 SHALL in CLEAR emit H_RES*V_RES plots, one per cycle, x inner 0..H_RES-1, y outer 0..V_RES-1, colour = latched fill colour; vga_plot continuously 1 for 19200 cycles at defaults.
REQ-012 SHALL during CLEAR still enqueue PLOT writes if space, draining them only after CLEAR completes.
REQ-013 SHALL never assert waitrequest for reads or when write=0; reads have no side effects.
REQ-014 SHALL report busy=1 when state is not IDLE or FIFO non-empty; fifo_level = current occupancy 0..FIFO_DEPTH.
REQ-015 SHALL ignore writedata bits [31], [15:8] for PLOT and [31:8] for CLEAR.
REQ-016 SHALL hold vga_x/vga_y/vga_colour at last-plotted values when vga_plot=0.

Reset
REQ-017 SHALL on reset=1 at an edge: state IDLE, FIFO empty, DROPPED=0, sweep counters 0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0, readdata=0, waitrequest=0.
REQ-018 SHALL abort any CLEAR or drain in progress on reset; no plot strobe in the cycle after reset is sampled.

Structure
REQ-019 SHALL place register addresses, field bit positions and the FSM state encoding in shared package vga_plot_pkg.
REQ-020 SHALL implement the queue as sub-module plot_fifo (synchronous, first-word fall-through, full/empty/level outputs).

Verification
REQ-021 Scenario: reset, PLOT x=5 y=7 colour=0xAA -> single vga_plot pulse with (5,7,0xAA) per REQ-009 latency, DROPPED=0.
REQ-022 Scenario: PLOT x=160 y=0 then x=0 y=120 -> no vga_plot, DROPPED reads 2, waitrequest never 1.
REQ-023 Scenario: 12 back-to-back PLOTs (0..11,0) -> waitrequest asserts when full, all 12 pixels emitted in order, none lost.
REQ-024 Scenario: CLEAR 0x3C -> 19200 consecutive pulses, first (0,0), last (159,119), all colour 0x3C, then busy=0.
REQ-025 Scenario: PLOT (1,1) then immediate CLEAR 0x00 -> (1,1) plotted first, CLEAR waits, then sweep; PLOT during sweep emitted after (159,119).
REQ-026 Scenario: reset asserted mid-CLEAR at pixel 100 -> next cycle vga_plot=0, STATUS reads 0, fresh PLOT works normally.
